// File: rtl/aria_round_ctrl.sv
// -----------------------------------------------------------------------------
// aria_round_ctrl
//
// Control FSM for an ARIA block-cipher core. It sequences key expansion and
// block processing against an external round counter. The counter is cleared
// by nr_clr, advanced by nr_en, and reports back through two flags:
// flg_klast for the last key-schedule step and flg_rlast for the last round.
//
// Request handshake: key_start and blk_start are single-cycle request pulses
// with no backpressure. A request is acted upon only when the FSM is idle
// (IDLE or KRDY), that is, when busy is 0. Requests that arrive while busy is 1
// are dropped silently. A request that is illegal in the current state is
// dropped and reported with a one-cycle err pulse one clock later. done is a
// one-cycle pulse in the final cycle of a block operation.
//
// Parameters
//   KEY_REQ    1: blk_start is rejected until a key expansion has completed.
//              0: blk_start is accepted in IDLE without a key check.
//
// Ports
//   clk        single clock; all state changes on its rising edge
//   rst        asynchronous active-high reset
//   key_start  request to run key expansion (ksize sampled on acceptance)
//   blk_start  request to process one block
//   ksize      key size: 01=128, 10=192, 11=256, 00=illegal
//   flg_klast  round counter: final key-schedule step reached
//   flg_rlast  round counter: final round reached
//   nr_clr     round counter clear
//   nr_en      round counter increment
//   st_ksize   latched key size, driven to the round counter
//   ks_en      key-schedule step enable
//   rnd_en     datapath round step enable
//   rnd_last   final-round select for the datapath
//   key_ready  expanded key is valid
//   busy       operation in progress
//   done       completion pulse for a block
//   err        rejected-request pulse
// -----------------------------------------------------------------------------
module aria_round_ctrl #(
  parameter int KEY_REQ = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start,
  input  logic       blk_start,
  input  logic [1:0] ksize,
  input  logic       flg_klast,
  input  logic       flg_rlast,
  output logic       nr_clr,
  output logic       nr_en,
  output logic [1:0] st_ksize,
  output logic       ks_en,
  output logic       rnd_en,
  output logic       rnd_last,
  output logic       key_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KINIT = 3'd1,
    KEXP  = 3'd2,
    KRDY  = 3'd3,
    RINIT = 3'd4,
    ROUND = 3'd5,
    DONE  = 3'd6
  } state_t;

  // The state register is visible hierarchically as "state" so that checkers
  // can bind to it directly.
  state_t state;
  state_t state_nx;

  logic key_acc;   // key_start accepted this cycle
  logic key_set;   // key expansion finishes this cycle
  logic err_nx;    // request rejected this cycle

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    key_acc  = 1'b0;
    key_set  = 1'b0;
    err_nx   = 1'b0;

    case (state)
      IDLE, KRDY: begin
        // key_start has priority. When it is present, blk_start is dropped
        // even if the key request itself is rejected for an illegal size.
        if (key_start) begin
          if (ksize != 2'b00) begin
            key_acc  = 1'b1;
            state_nx = KINIT;
          end else begin
            err_nx = 1'b1;
          end
        end else if (blk_start) begin
          if ((state == KRDY) || (KEY_REQ == 0)) begin
            state_nx = RINIT;
          end else begin
            err_nx = 1'b1;
          end
        end
      end

      KINIT: begin
        state_nx = KEXP;
      end

      KEXP: begin
        if (flg_klast) begin
          key_set  = 1'b1;
          state_nx = KRDY;
        end
      end

      RINIT: begin
        state_nx = ROUND;
      end

      ROUND: begin
        if (flg_rlast) begin
          state_nx = DONE;
        end
      end

      DONE: begin
        // The key stays valid, so the FSM returns to KRDY for the next block.
        state_nx = KRDY;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered status: latched key size, key validity, and error pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_ksize  <= 2'b00;
      key_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= err_nx;
      if (key_acc) begin
        st_ksize  <= ksize;
        key_ready <= 1'b0;
      end else if (key_set) begin
        key_ready <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control outputs are decoded from the state. The counter flags are used
  // only in KEXP and ROUND. The counter increments on every step except the
  // last one, so it holds its final value when the FSM leaves the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    nr_clr   = 1'b0;
    nr_en    = 1'b0;
    ks_en    = 1'b0;
    rnd_en   = 1'b0;
    rnd_last = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    case (state)
      KINIT: begin
        busy   = 1'b1;
        nr_clr = 1'b1;
      end
      KEXP: begin
        busy  = 1'b1;
        ks_en = 1'b1;
        nr_en = ~flg_klast;
      end
      RINIT: begin
        busy   = 1'b1;
        nr_clr = 1'b1;
      end
      ROUND: begin
        busy     = 1'b1;
        rnd_en   = 1'b1;
        nr_en    = ~flg_rlast;
        rnd_last = flg_rlast;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/aria_round_ctrl.md
ARIA_ROUND_CTRL -- requirements
Module: aria_round_ctrl

Interface
REQ-001 The block SHALL have parameter KEY_REQ, default 1, meaning blk_start is rejected until a key expansion has completed (0 = no key check).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port key_start, input, 1, a one-cycle request to run key expansion.
REQ-005 The block SHALL have port blk_start, input, 1, a one-cycle request to process one block.
REQ-006 The block SHALL have port ksize, input, 2, the key size (01=128, 10=192, 11=256, 00=illegal), sampled only when key_start is accepted.
REQ-007 The block SHALL have ports flg_klast and flg_rlast, input, 1 each, the status flags from the round counter.
REQ-008 The block SHALL have ports nr_clr and nr_en, output, 1 each, the round counter clear and increment.
REQ-009 The block SHALL have port st_ksize, output, 2, the latched key size driven to the round counter.
REQ-010 The block SHALL have ports ks_en, rnd_en and rnd_last, output, 1 each: key-schedule step, datapath round step, and final-round select.
REQ-011 The block SHALL have ports key_ready, busy, done and err, output, 1 each: key valid, operation in progress, completion pulse, and rejected-request pulse.

Function
REQ-012 The FSM SHALL have states IDLE, KINIT, KEXP, KRDY, RINIT, ROUND and DONE, held in a state register.
REQ-013 In IDLE or KRDY, a key_start with ksize!=00 SHALL latch ksize into st_ksize, clear key_ready, and go to KINIT.
REQ-014 In IDLE or KRDY, a key_start with ksize==00 SHALL pulse err for 1 cycle and leave state, st_ksize and key_ready unchanged.
REQ-015 KINIT SHALL last 1 cycle with nr_clr=1, then go to KEXP.
REQ-016 KEXP SHALL assert ks_en every cycle and nr_en=!flg_klast; when flg_klast=1 the FSM SHALL go to KRDY, so KEXP lasts exactly 4 cycles.
REQ-017 Entering KRDY SHALL set key_ready=1; key_ready SHALL stay 1 until the next accepted key_start or reset.
REQ-018 In KRDY, blk_start SHALL go to RINIT; in IDLE with KEY_REQ=1, blk_start SHALL pulse err and be ignored.
REQ-019 RINIT SHALL last 1 cycle with nr_clr=1, then go to ROUND.
REQ-020 ROUND SHALL assert rnd_en every cycle, nr_en=!flg_rlast and rnd_last=flg_rlast; when flg_rlast=1 the FSM SHALL go to DONE.
REQ-021 ROUND SHALL therefore last 12, 14 or 16 cycles for ksize 01, 10 or 11.
REQ-022 DONE SHALL last 1 cycle with done=1, then go to KRDY; the key SHALL remain valid for back-to-back blocks.
REQ-023 Latency from a blk_start edge to the done cycle SHALL be 14, 16 or 18 cycles for 128, 192 or 256.
REQ-024 busy SHALL be 1 in KINIT, KEXP, RINIT, ROUND and DONE, and 0 in IDLE and KRDY.
REQ-025 key_start and blk_start received while busy SHALL be ignored, with no err.
REQ-026 When key_start and blk_start arrive in the same cycle in KRDY, key_start SHALL win and blk_start SHALL be dropped.
REQ-027 A change on ksize during an operation SHALL have no effect; only st_ksize is used.
REQ-028 nr_clr and nr_en SHALL never be 1 in the same cycle.
REQ-029 ks_en and rnd_en SHALL never be 1 in the same cycle.
REQ-030 All control outputs SHALL be decoded from the state, plus the flag inputs only where stated above.

Reset
REQ-031 While rst=1, asynchronously and at any point: state SHALL be IDLE, st_ksize=00, and key_ready, busy, done, err, nr_clr, nr_en, ks_en, rnd_en and rnd_last SHALL all be 0.
REQ-032 A reset during KEXP or ROUND SHALL abort the operation, invalidate the key, and produce no done pulse.
REQ-033 After reset is released, the first key_start SHALL be accepted on the next rising edge.

Verification
REQ-034 Scenario: key_start with ksize=01, then blk_start in KRDY -> KEXP 4 cycles with ks_en=1; ROUND 12 cycles; rnd_last=1 only in ROUND cycle 12; done 14 cycles after blk_start.
REQ-035 Scenario: ksize=11 then two back-to-back blocks -> each has 16 rnd_en cycles and a done pulse 18 cycles after its start; key_ready stays 1 throughout.
REQ-036 Scenario: key_start with ksize=00 and, separately, blk_start in IDLE -> err 1-cycle pulse each, state unchanged, key_ready=0.
REQ-037 Scenario: key_start and blk_start in the same cycle in KRDY -> KINIT entered; no rnd_en until a new blk_start.
REQ-038 Scenario: rst=1 asserted in ROUND cycle 5 -> all outputs 0 immediately; no done; key_ready=0 after release.
REQ-039 Scenario: starts pulsed and ksize toggled during ROUND -> cycle counts and st_ksize unchanged, no err.
